regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single register-file write port: arbitrates ALU and LSU writeback
//  requests, registers the winner onto rd_w/rd_sel/rd_in, and keeps a busy
//  scoreboard of registers with outstanding loads. Flags RAW hazards to the
//  decode stage so it stalls register-file reads. Sits between execute/LSU and
//  the register file.
// PARAMETERS
//  XLEN         32  data width
//  NREGS        32  architectural registers; AW = $clog2(NREGS) = 5
//  STARVE_LIMIT 4   consecutive cycles an eligible ALU request may lose before it must win
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst_n        in   1     async active-low reset
//  alu_valid    in   1     ALU writeback request
//  alu_ready    out  1     ALU request accepted this cycle (comb)
//  alu_rd       in   AW    ALU destination
//  alu_data     in   XLEN  ALU result
//  lsu_valid    in   1     load-data writeback request
//  lsu_ready    out  1     LSU request accepted this cycle (comb)
//  lsu_rd       in   AW    load destination
//  lsu_data     in   XLEN  load data
//  sb_set_valid in   1     load issued; mark sb_set_rd busy
//  sb_set_rd    in   AW    destination of issued load
//  sb_set_ready out  1     issue allowed = !busy[sb_set_rd] || sb_set_rd==0 (comb)
//  rs1_sel      in   AW    decode read select 1
//  rs2_sel      in   AW    decode read select 2
//  rs1_en       in   1     rs1 used
//  rs2_en       in   1     rs2 used
//  hazard       out  1     stall decode (comb)
//  rd_w         out  1     register-file write enable (registered)
//  rd_sel       out  AW    register-file write select (registered)
//  rd_in        out  XLEN  register-file write data (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): rd_w=0, rd_sel=0, rd_in=0, busy[] all 0, starve_cnt=0.
//    A write already in the output register is dropped; nothing pending survives.
//  - ALU eligible: alu_valid && !(busy[alu_rd] && alu_rd!=0). An ALU write to a
//    register with a pending load is held (WAW) and does not count as starving.
//  - Grant, at most one per cycle: if ALU eligible && starve_cnt==STARVE_LIMIT,
//    grant ALU; else if lsu_valid, grant LSU; else if ALU eligible, grant ALU.
//  - starve_cnt: 0 when ALU granted or ALU not eligible; +1 (saturating at
//    STARVE_LIMIT) when ALU eligible and LSU granted.
//  - Transfer happens when valid && ready in the same cycle. Data, rd must be
//    stable while valid && !ready; valid must not drop before ready.
//  - Latency 1: on the edge after acceptance rd_w=1, rd_sel/rd_in = accepted
//    rd/data. With no grant, rd_w=0 and rd_sel/rd_in hold their last value.
//  - rd==0 writes are accepted (ready=1), but rd_w stays 0 the next cycle.
//  - Scoreboard: an accepted LSU write clears busy[lsu_rd]. sb_set_valid &&
//    sb_set_ready sets busy[sb_set_rd]. Set and clear of the same register in
//    the same cycle: set wins. busy[0] is never set.
//  - hazard = (rs1_en && rs1_sel!=0 && (busy[rs1_sel] || (rd_w && rd_sel==rs1_sel)))
//    || the same term for rs2. The second term covers the write in flight,
//    because the register file commits on the next edge.
// TESTING
//  1 Reset mid-stream: load issued to x5, then rst_n=0 -> busy[5]=0, rd_w=0, hazard=0 for rs1=5.
//  2 Both valid, ALU eligible, lsu_valid held 1 -> LSU granted for 4 cycles, ALU
//    granted on cycle 5, starve_cnt then 0.
//  3 sb_set x7; alu_valid rd=7 -> alu_ready=0 until LSU writes x7. Next cycle rd_w=1,
//    rd_sel=7, rd_in=lsu_data; ALU is granted the following cycle.
//  4 ALU write x3=0xDEADBEEF accepted at cycle N -> cycle N+1 rd_w=1, rd_sel=3,
//    rd_in=0xDEADBEEF, and hazard=1 for rs2_sel=3, rs2_en=1.
//  5 ALU write rd=0 -> alu_ready=1, next cycle rd_w=0. sb_set rd=0 -> busy stays
//    clear and hazard=0 for rs1=0.
//  6 LSU clears x9 in the same cycle sb_set x9 -> busy[9]=1 afterwards.
//    sb_set_ready=0 for x9 while it is busy.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/LSU writeback onto the single register-file
// write port, tracks registers with outstanding loads, and flags RAW hazards.
//   clk, rst_n                          clock, async active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data ALU writeback handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data load-data writeback handshake
//   sb_set_valid/sb_set_ready/sb_set_rd load issue, marks destination busy
//   rs1_sel/rs1_en/rs2_sel/rs2_en       decode read operands
//   hazard                              stall decode
//   rd_w/rd_sel/rd_in                   registered register-file write port
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(NREGS),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            sb_set_valid,
    input  logic [AW-1:0]   sb_set_rd,
    output logic            sb_set_ready,
    input  logic [AW-1:0]   rs1_sel,
    input  logic [AW-1:0]   rs2_sel,
    input  logic            rs1_en,
    input  logic            rs2_en,
    output logic            hazard,
    output logic            rd_w,
    output logic [AW-1:0]   rd_sel,
    output logic [XLEN-1:0] rd_in
);
    logic [NREGS-1:0] busy, busy_nxt;
    logic [SW-1:0]    starve_cnt, starve_nxt;
    logic             alu_elig, alu_force, set_en, h1, h2;

    // An ALU write to a register awaiting load data is held back so the
    // older load cannot overwrite it later.
    assign alu_elig     = alu_valid && !(busy[alu_rd] && alu_rd != '0);
    assign alu_force    = alu_elig && starve_cnt == SW'(STARVE_LIMIT);
    assign alu_ready    = alu_force || (!lsu_valid && alu_elig);
    assign lsu_ready    = lsu_valid && !alu_force;
    assign sb_set_ready = !busy[sb_set_rd] || sb_set_rd == '0;
    assign set_en       = sb_set_valid && sb_set_ready && sb_set_rd != '0;

    // The write in the output register lands on the next edge, so a reader
    // of that register must also wait.
    assign h1     = rs1_en && rs1_sel != '0 && (busy[rs1_sel] || (rd_w && rd_sel == rs1_sel));
    assign h2     = rs2_en && rs2_sel != '0 && (busy[rs2_sel] || (rd_w && rd_sel == rs2_sel));
    assign hazard = h1 || h2;

    always_comb begin
        busy_nxt = busy;
        if (lsu_ready) busy_nxt[lsu_rd] = 1'b0;
        if (set_en) busy_nxt[sb_set_rd] = 1'b1;
        starve_nxt = (alu_elig && lsu_ready)
                   ? (alu_force ? starve_cnt : starve_cnt + SW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_w       <= 1'b0;
            rd_sel     <= '0;
            rd_in      <= '0;
            busy       <= '0;
            starve_cnt <= '0;
        end else begin
            rd_w       <= (alu_ready && alu_rd != '0) || (lsu_ready && lsu_rd != '0);
            busy       <= busy_nxt;
            starve_cnt <= starve_nxt;
            if (alu_ready) begin
                rd_sel <= alu_rd;
                rd_in  <= alu_data;
            end else if (lsu_ready) begin
                rd_sel <= lsu_rd;
                rd_in  <= lsu_data;
            end
        end
    end
endmodule
